// File: rtl/bridge_utils.sv
// Types shared between the bridge engine and its APB4 requester stage.
package bridge_utils;

    typedef enum logic [1:0] {
        APB_DISABLE = 2'b00,
        APB_READ    = 2'b01,
        APB_WRITE   = 2'b10
    } apb_cmd_t;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_BUSY   = 2'b01,
        APB_SWITCH = 2'b10
    } apb_info_t;

    // AXI-coded response returned to the engine
    typedef logic [1:0] apb_resp_t;
    localparam apb_resp_t RESP_OKAY   = 2'b00;
    localparam apb_resp_t RESP_SLVERR = 2'b10;
    localparam apb_resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } apb_state_t;

    function automatic apb_resp_t resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/bridge_apb_decoder.sv
// Slave decode for the APB requester: range check, one-hot select and
// per-slave response mux, all combinational on the slave index.
module bridge_apb_decoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SLAVES    = 4,
    parameter int SLV_SEL_WIDTH = 4
) (
    input  logic [SLV_SEL_WIDTH-1:0]         idx,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic                             hit,
    output logic [NUM_SLAVES-1:0]            sel,
    output logic                             sel_ready,
    output logic [DATA_WIDTH-1:0]            sel_rdata,
    output logic                             sel_err
);

    localparam logic [SLV_SEL_WIDTH:0] NUM_SLV_W = (SLV_SEL_WIDTH+1)'(NUM_SLAVES);

    assign hit = ({1'b0, idx} < NUM_SLV_W);

    // One-hot select and response mux; unselected slaves never contribute
    always_comb begin
        sel       = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit && (idx == SLV_SEL_WIDTH'(i))) begin
                sel[i]    = 1'b1;
                sel_ready = pready[i];
                sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_err   = pslverr[i];
            end else begin
                sel[i]    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bridge_apb_master.sv
// APB4 requester stage: decodes the slave, runs SETUP/ACCESS with a PREADY
// timeout and hands read data plus an AXI-coded response back to the engine.
module bridge_apb_master
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_SEL_LSB    = 12,
    parameter int SLV_SEL_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  apb_cmd_t                         apb_cmd,
    output apb_info_t                        apb_info,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_wstrb,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    apb_state_t              state_r, state_s;
    apb_info_t               info_r, info_s;
    logic [NUM_SLAVES-1:0]   psel_r, psel_s;
    logic                    penable_r, penable_s;
    logic                    pwrite_r, pwrite_s;
    logic [ADDR_WIDTH-1:0]   paddr_r, paddr_s;
    logic [DATA_WIDTH-1:0]   pwdata_r, pwdata_s;
    logic [STRB_WIDTH-1:0]   pstrb_r, pstrb_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
    apb_resp_t               resp_r, resp_s;
    logic [CNT_WIDTH-1:0]    cnt_r, cnt_s, cnt_inc_s;

    logic [SLV_SEL_WIDTH-1:0] idx_s;
    logic                     hit_s, sel_ready_s, sel_err_s;
    logic [NUM_SLAVES-1:0]    sel_s;
    logic [DATA_WIDTH-1:0]    sel_rdata_s;
    logic                     is_write_s;

    // Decode the incoming request while idle, the latched address otherwise
    assign idx_s      = (state_r == ST_IDLE) ? req_addr[SLV_SEL_LSB +: SLV_SEL_WIDTH]
                                             : paddr_r[SLV_SEL_LSB +: SLV_SEL_WIDTH];
    assign is_write_s = (apb_cmd == APB_WRITE);
    assign cnt_inc_s  = cnt_r + CNT_WIDTH'(1);

    bridge_apb_decoder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_SLAVES    (NUM_SLAVES),
        .SLV_SEL_WIDTH (SLV_SEL_WIDTH)
    ) u_decoder (
        .idx       (idx_s),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .hit       (hit_s),
        .sel       (sel_s),
        .sel_ready (sel_ready_s),
        .sel_rdata (sel_rdata_s),
        .sel_err   (sel_err_s)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_s   = state_r;
        info_s    = info_r;
        psel_s    = psel_r;
        penable_s = penable_r;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        pstrb_s   = pstrb_r;
        rdata_s   = rdata_r;
        resp_s    = resp_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                info_s = APB_IDLE;
                if (apb_cmd != APB_DISABLE) begin
                    pwrite_s = is_write_s;
                    paddr_s  = req_addr;
                    pwdata_s = is_write_s ? req_wdata : '0;
                    pstrb_s  = is_write_s ? req_wstrb : '0;
                    if (hit_s) begin
                        state_s   = ST_SETUP;
                        psel_s    = sel_s;
                        penable_s = 1'b0;
                        info_s    = APB_BUSY;
                    end else begin
                        // Decode miss answers directly without touching the bus
                        state_s   = ST_DONE;
                        rdata_s   = '0;
                        resp_s    = RESP_DECERR;
                        info_s    = APB_SWITCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                penable_s = 1'b1;
                info_s    = APB_BUSY;
            end
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    state_s   = ST_DONE;
                    psel_s    = '0;
                    penable_s = 1'b0;
                    rdata_s   = pwrite_r ? '0 : sel_rdata_s;
                    resp_s    = resp_from_err(sel_err_s);
                    info_s    = APB_SWITCH;
                end else if (TIMEOUT_EN && (cnt_inc_s == CNT_LIMIT)) begin
                    state_s   = ST_DONE;
                    psel_s    = '0;
                    penable_s = 1'b0;
                    rdata_s   = '0;
                    resp_s    = RESP_SLVERR;
                    info_s    = APB_SWITCH;
                    cnt_s     = cnt_inc_s;
                end else begin
                    // With the timeout disabled the counter stays parked
                    cnt_s     = TIMEOUT_EN ? cnt_inc_s : cnt_r;
                    info_s    = APB_BUSY;
                end
            end
            ST_DONE: begin
                state_s   = ST_IDLE;
                psel_s    = '0;
                penable_s = 1'b0;
                info_s    = APB_IDLE;
                cnt_s     = '0;
            end
            default: begin
                state_s   = ST_IDLE;
                psel_s    = '0;
                penable_s = 1'b0;
                info_s    = APB_IDLE;
                cnt_s     = '0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any bus transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            info_r    <= APB_IDLE;
            psel_r    <= '0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            rdata_r   <= '0;
            resp_r    <= RESP_OKAY;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_s;
            info_r    <= info_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            pstrb_r   <= pstrb_s;
            rdata_r   <= rdata_s;
            resp_r    <= resp_s;
            cnt_r     <= cnt_s;
        end
    end

    assign apb_info  = info_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign pstrb     = pstrb_r;
    assign rsp_rdata = rdata_r;
    assign rsp_resp  = resp_r;

endmodule

// File: doc/bridge_apb_master.md
Name: bridge_apb_master

Overview:
- APB4 requester stage directly downstream of the bridge engine. Consumes one-cycle `apb_cmd` pulses (APB_READ/APB_WRITE) plus the latched request address, data and strobe.
- Decodes the target slave, runs the SETUP/ACCESS protocol and enforces a PREADY timeout.
- Returns read data and an AXI-coded response, then pulses `apb_info = APB_SWITCH` so the engine advances.

Parameters:
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width (multiple of 8).
- NUM_SLAVES, 4, number of psel lines (1..2**SLV_SEL_WIDTH).
- SLV_SEL_LSB, 12, lowest address bit of the slave-select field.
- SLV_SEL_WIDTH, 4, width of the slave-select field.
- TIMEOUT_CYCLES, 256, max ACCESS cycles without PREADY; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- apb_cmd  in  apb_cmd_t  APB_DISABLE/APB_READ/APB_WRITE, one-cycle pulse from engine.
- apb_info  out  apb_info_t  APB_IDLE/APB_BUSY/APB_SWITCH.
- req_addr  in  ADDR_WIDTH  request address, valid with apb_cmd.
- req_wdata  in  DATA_WIDTH  write data, valid with APB_WRITE.
- req_wstrb  in  DATA_WIDTH/8  write strobes, valid with APB_WRITE.
- rsp_rdata  out  DATA_WIDTH  read data, valid while apb_info==APB_SWITCH.
- rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR; valid with APB_SWITCH.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  1 = write.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB write strobes.
- pready  in  NUM_SLAVES  per-slave ready.
- prdata  in  NUM_SLAVES x DATA_WIDTH  per-slave read data.
- pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (rst high at an edge):
  - State IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
  - rsp_rdata=0, rsp_resp=00, apb_info=APB_IDLE, timeout counter=0.
  - Reset mid-transfer drops psel/penable at that edge with no APB_SWITCH; the slave sees an aborted transfer.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE, apb_cmd != APB_DISABLE:
  - Latch addr, wdata, wstrb and direction.
  - idx = req_addr[SLV_SEL_LSB +: SLV_SEL_WIDTH].
  - If idx < NUM_SLAVES: go to SETUP.
  - Otherwise (decode miss): go to DONE with rsp_resp=11 and rsp_rdata=0; no psel is ever asserted.
- SETUP (1 cycle):
  - psel[idx]=1, penable=0, paddr/pwrite driven.
  - Writes: pwdata/pstrb from the latch. Reads: pwdata=0, pstrb=0.
  - Always go to ACCESS.
- ACCESS:
  - penable=1; all APB outputs held stable.
  - If pready[idx]: capture prdata[idx] (reads) or 0 (writes); rsp_resp = pslverr[idx] ? 10 : 00; go to DONE.
  - Otherwise increment the counter. If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES, go to DONE with rsp_resp=10, rsp_rdata=0.
  - pready/pslverr of unselected slaves are ignored.
- DONE (exactly 1 cycle):
  - psel=0, penable=0; apb_info=APB_SWITCH; rsp_* valid.
  - Clear the counter; go to IDLE.
- apb_info is APB_BUSY in SETUP/ACCESS and APB_IDLE in IDLE.
- rsp_rdata/rsp_resp hold their value until the next DONE.
- Latency, zero-wait-state slave: cmd at edge N; SETUP N+1; ACCESS N+2; DONE N+3; IDLE N+4. Each wait state adds 1 cycle.
- apb_cmd asserted outside IDLE is ignored; no queueing.
- Back-to-back: a new cmd accepted in the IDLE cycle right after DONE is legal.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1); it cannot wrap.

Decomposition:
- Package `bridge_utils`:
  - apb_cmd_t and apb_info_t (shared with the engine).
  - New `apb_resp_t` constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - `apb_state_t` enum.
- Sub-module `bridge_apb_decoder`:
  - Combinational idx extraction, range check to a hit flag, one-hot psel vector.
  - Response mux of pready/prdata/pslverr by idx.
- The FSM and timeout counter live in `bridge_apb_master`.

Test Plan:
- Zero-wait read:
  - Stimulus: APB_READ, addr 0x0000_1004; slave1 pready=1, prdata=0xDEADBEEF.
  - Required response: psel=4'b0010 at N+1, penable at N+2, APB_SWITCH at N+3 with rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Write with 3 wait states:
  - Stimulus: APB_WRITE, addr 0x0000_3010, wdata 0x12345678, wstrb 0x5; slave3 pready low for 3 ACCESS cycles.
  - Required response: pwdata/pstrb/paddr stable throughout; APB_SWITCH at N+6; rsp_resp=00.
- Slave error:
  - Stimulus: read of slave0 returns pready=1, pslverr=1.
  - Required response: rsp_resp=10 while APB_SWITCH.
- Decode miss:
  - Stimulus: addr 0x0000_7000 (idx 7, NUM_SLAVES=4).
  - Required response: psel never asserted; APB_SWITCH at N+1 with rsp_resp=11, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; pready held 0.
  - Required response: psel/penable drop after 8 ACCESS cycles; APB_SWITCH with rsp_resp=10. Repeat with TIMEOUT_CYCLES=0: no timeout after 1000 cycles.
- Reset mid-ACCESS:
  - Stimulus: rst pulsed during a write wait state.
  - Required response: all outputs at reset values at the next edge; no APB_SWITCH; a subsequent read completes normally.
